// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the IF stage.
// Consumed by fetch_stage and its IF/ID register.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_HOLD,
    S_KILL
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h0;
  localparam logic [31:0] PC_INC    = 32'd4;

endpackage

// File: rtl/fetch_flopenrc.sv
// flopenrc: register with enable and synchronous clear.
// Used for the IF/ID pipeline register.
module flopenrc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset)
      q <= '0;
    else if (clr)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem port, IF/ID register.
// FETCH_PERF_EN adds perf_fetched/perf_bubbles counters.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        pcsrcM,
  input  logic        jumpM,
  input  logic [31:0] pcbranchM,
  input  logic [31:0] pcjumpM,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instrD,
  output logic [5:0]  opD,
  output logic [5:0]  functD,
  output logic [31:0] pcplus4D,
  output logic        validD,
  output logic        fetch_busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  fetch_state_t state, state_n;
  logic [31:0] pcF, pcF_n;
  logic [31:0] req_addr, req_addr_n;
  logic [31:0] instr_buf, buf_n;
  logic [31:0] pcplus4F, target, load_instr;
  logic        redirect, load, bubble;
  logic [32:0] ifid_q;

  assign redirect = pcsrcM | jumpM;
  assign target   = pcsrcM ? pcbranchM : pcjumpM;
  assign pcplus4F = pcF + PC_INC;

  always_comb begin
    state_n    = state;
    pcF_n      = pcF;
    req_addr_n = req_addr;
    buf_n      = instr_buf;
    load       = 1'b0;
    load_instr = imem_rdata;
    unique case (state)
      S_REQ: begin
        if (redirect) begin
          pcF_n = target;
          if (!imem_valid) begin
            req_addr_n = pcF;
            state_n    = S_KILL;
          end
        end else if (imem_valid) begin
          if (stallD || flushD) begin
            buf_n   = imem_rdata;
            state_n = S_HOLD;
          end else begin
            load  = 1'b1;
            pcF_n = pcplus4F;
          end
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pcF_n   = target;
          state_n = S_REQ;
        end else if (!stallD && !flushD) begin
          load       = 1'b1;
          load_instr = instr_buf;
          pcF_n      = pcplus4F;
          state_n    = S_REQ;
        end
      end
      S_KILL: begin
        if (redirect)
          pcF_n = target;
        // the killed word is dropped; only leave once it lands
        if (imem_valid)
          state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_REQ;
      pcF       <= RESET_PC;
      req_addr  <= RESET_PC;
      instr_buf <= NOP_INSTR;
    end else begin
      state     <= state_n;
      pcF       <= pcF_n;
      req_addr  <= req_addr_n;
      instr_buf <= buf_n;
    end
  end

  assign bubble     = redirect | flushD | (!stallD & !load);
  assign imem_req   = !reset && (state != S_HOLD);
  assign imem_addr  = (state == S_KILL) ? req_addr : pcF;
  assign fetch_busy = !reset && (state != S_REQ);

  flopenrc #(.WIDTH(33)) u_ifid_iv (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .clr   (bubble),
    .d     ({1'b1, load_instr}),
    .q     (ifid_q)
  );

  // pcplus4D is not cleared by a bubble
  flopenrc #(.WIDTH(32)) u_ifid_pc (
    .clk   (clk),
    .reset (reset),
    .en    (load),
    .clr   (1'b0),
    .d     (pcplus4F),
    .q     (pcplus4D)
  );

  assign validD = ifid_q[32];
  assign instrD = ifid_q[31:0];
  assign opD    = instrD[31:26];
  assign functD = instrD[5:0];

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (load)
        perf_fetched <= perf_fetched + 32'd1;
      if (bubble)
        perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with a queue scoreboard.
// A negedge monitor checks accepted requests and IF/ID loads.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stallD = 1'b0, flushD = 1'b0;
  logic        pcsrcM = 1'b0, jumpM = 1'b0;
  logic [31:0] pcbranchM = '0, pcjumpM = '0;
  logic        imem_req, imem_valid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instrD, pcplus4D;
  logic [5:0]  opD, functD;
  logic        validD, fetch_busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_bubbles;
`endif

  typedef struct {
    logic [31:0] ins;
    logic [31:0] pc4;
  } del_t;

  logic [31:0] addr_q[$];
  del_t        del_q[$];
  del_t        last;
  int          tests = 0, fails = 0;
  int          lat = 0, wcnt = 0;
  logic        hold_q = 1'b0;

  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'h2008_0005 + (a << 16) + (a >> 2);
  endfunction

  fetch_stage dut (
    .clk(clk), .reset(reset), .stallD(stallD), .flushD(flushD),
    .pcsrcM(pcsrcM), .jumpM(jumpM),
    .pcbranchM(pcbranchM), .pcjumpM(pcjumpM),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instrD(instrD), .opD(opD), .functD(functD),
    .pcplus4D(pcplus4D), .validD(validD), .fetch_busy(fetch_busy)
`ifdef FETCH_PERF_EN
    , .perf_fetched(perf_fetched), .perf_bubbles(perf_bubbles)
`endif
  );

  always #5 clk = ~clk;

  assign imem_valid = imem_req && (wcnt >= lat);
  assign imem_rdata = word(imem_addr);

  always @(posedge clk) begin
    if (reset || !imem_req || imem_valid) wcnt <= 0;
    else wcnt <= wcnt + 1;
    hold_q <= stallD && !flushD && !pcsrcM && !jumpM && !reset;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (imem_req && imem_valid) begin
        if (addr_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL req_addr: got %h, expected none", imem_addr);
        end else chk("req_addr", imem_addr, addr_q.pop_front());
      end
      if (validD) begin
        if (hold_q) chk("held_instr", instrD, last.ins);
        else if (del_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL delivery: got %h, expected none", instrD);
        end else begin
          last = del_q.pop_front();
          chk("instrD", instrD, last.ins);
          chk("opD", {26'b0, opD}, {26'b0, last.ins[31:26]});
          chk("functD", {26'b0, functD}, {26'b0, last.ins[5:0]});
          chk("pcplus4D", pcplus4D, last.pc4);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push_a(input logic [31:0] a);
    addr_q.push_back(a);
  endtask

  task automatic push_d(input logic [31:0] a);
    del_t d;
    d.ins = word(a);
    d.pc4 = a + 32'd4;
    del_q.push_back(d);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stallD = 0; flushD = 0; pcsrcM = 0; jumpM = 0;
    @(negedge clk);
    chk("req_in_reset", {31'b0, imem_req}, 32'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic check_rst();
    @(negedge clk);
    chk("rst_instrD", instrD, 32'h0);
    chk("rst_opD", {26'b0, opD}, 32'h0);
    chk("rst_functD", {26'b0, functD}, 32'h0);
    chk("rst_pcplus4D", pcplus4D, 32'h0);
    chk("rst_validD", {31'b0, validD}, 32'd0);
    chk("rst_busy", {31'b0, fetch_busy}, 32'd0);
    chk("rst_req", {31'b0, imem_req}, 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
`ifdef FETCH_PERF_EN
    chk("rst_perf_fetched", perf_fetched, 32'h0);
    chk("rst_perf_bubbles", perf_bubbles, 32'h0);
`endif
  endtask

  task automatic end_scn();
    chk("addr_q_empty", addr_q.size(), 32'd0);
    chk("del_q_empty", del_q.size(), 32'd0);
    addr_q.delete();
    del_q.delete();
  endtask

  initial begin
    // zero-wait stream, then a 3-cycle stall as word 12 returns
    lat = 0;
    push_a(0); push_a(4); push_a(8); push_a(12); push_a(16);
    push_d(0); push_d(4); push_d(8); push_d(12);
    do_reset();
    check_rst();
    tick();
    @(negedge clk);
    chk("first_instr", instrD, 32'h2008_0005);
    chk("first_op", {26'b0, opD}, 32'h08);
    chk("first_pc4", pcplus4D, 32'd4);
    tick(); tick();
    stallD = 1;
    tick();
    @(negedge clk);
    chk("hold_req", {31'b0, imem_req}, 32'd0);
    chk("hold_busy", {31'b0, fetch_busy}, 32'd1);
    chk("hold_instr", instrD, word(32'h8));
    tick(); tick();
    stallD = 0;
    @(negedge clk);
    chk("hold_busy2", {31'b0, fetch_busy}, 32'd1);
    tick();
    @(negedge clk);
    chk("release_instr", instrD, word(32'hC));
    tick();
    end_scn();

    // 2-cycle memory, branch kills request to 8
    lat = 2;
    push_a(0); push_a(4); push_a(8); push_a(32'h40);
    push_d(0); push_d(4); push_d(32'h40);
    do_reset();
    repeat (6) tick();
    pcsrcM = 1; pcbranchM = 32'h40;
    tick();
    pcsrcM = 0;
    @(negedge clk);
    chk("kill_addr", imem_addr, 32'h8);
    chk("kill_busy", {31'b0, fetch_busy}, 32'd1);
    chk("kill_valid", {31'b0, validD}, 32'd0);
    tick();
    @(negedge clk);
    chk("kill_addr2", imem_addr, 32'h8);
    tick();
    @(negedge clk);
    chk("target_addr", imem_addr, 32'h40);
    chk("kill_valid2", {31'b0, validD}, 32'd0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("target_instr", instrD, word(32'h40));
    tick();
    end_scn();

    // branch and jump together: branch wins
    lat = 0;
    push_a(0); push_a(32'h100); push_a(32'h104);
    push_d(32'h100);
    do_reset();
    pcsrcM = 1; jumpM = 1; pcbranchM = 32'h100; pcjumpM = 32'h200;
    tick();
    pcsrcM = 0; jumpM = 0;
    @(negedge clk);
    chk("prio_addr", imem_addr, 32'h100);
    chk("prio_valid", {31'b0, validD}, 32'd0);
    tick();
    @(negedge clk);
    chk("prio_pc4", pcplus4D, 32'h104);
    tick();
    end_scn();

    // flush on the returning word: bubble, then load, no refetch
    lat = 0;
    push_a(0); push_a(4);
    push_d(0);
    do_reset();
    flushD = 1;
    tick();
    flushD = 0;
    @(negedge clk);
    chk("flush_valid", {31'b0, validD}, 32'd0);
    chk("flush_instr", instrD, 32'h0);
    chk("flush_req", {31'b0, imem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("flush_load", instrD, word(32'h0));
    tick();
    end_scn();

    // jump to the top of memory: PC+4 wraps to 0
    lat = 0;
    push_a(0); push_a(32'hFFFF_FFFC); push_a(0);
    push_d(32'hFFFF_FFFC);
    do_reset();
    jumpM = 1; pcjumpM = 32'hFFFF_FFFC;
    tick();
    jumpM = 0;
    tick();
    @(negedge clk);
    chk("wrap_pc4", pcplus4D, 32'h0);
    tick();
    end_scn();

    // reset while in S_KILL
    lat = 2;
    do_reset();
    pcsrcM = 1; pcbranchM = 32'h80;
    tick();
    pcsrcM = 0;
    @(negedge clk);
    chk("kill_state_busy", {31'b0, fetch_busy}, 32'd1);
    tick();
    reset = 1;
    tick();
    reset = 0;
    push_a(0);
    push_d(0);
    check_rst();
    tick(); tick(); tick();
    @(negedge clk);
    chk("restart_valid", {31'b0, validD}, 32'd1);
`ifdef FETCH_PERF_EN
    chk("perf_fetched", perf_fetched, 32'd1);
    chk("perf_bubbles", perf_bubbles, 32'd2);
`endif
    tick();
    end_scn();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
